// File: rtl/mem_access_sequencer.sv
// Initiator-side RAM access sequencer.
// It takes one read or write request at a time, drives the RAM port and waits
// for MFC. The access ends with a one-cycle Done pulse. A wait counter bounds
// every access, so a memory that never answers cannot hang the control unit.
module mem_access_sequencer #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int SETUP_CYCLES   = 1,   // 1..15
    parameter int TIMEOUT_CYCLES = 16   // 1..255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req_Read,
    input  logic                  Req_Write,
    input  logic [ADDR_WIDTH-1:0] Req_Address,
    input  logic [DATA_WIDTH-1:0] Req_Write_Data,
    input  logic                  Error_Clear,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Read_Data,
    output logic                  Timeout_Error,
    output logic [ADDR_WIDTH-1:0] RAM1_Address,
    output logic                  RAM1_Read_H_Write_L,
    output logic                  RAM1_Out_Enable,
    output logic [DATA_WIDTH-1:0] RAM1_Data_In,
    input  logic [DATA_WIDTH-1:0] RAM1_Data_Out,
    input  logic                  RAM1_MFC
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_ACCESS   = 3'd2,
        ST_COMPLETE = 3'd3,
        ST_FAIL     = 3'd4,
        ST_RELEASE  = 3'd5
    } state_t;

    localparam logic [3:0] SETUP_LAST   = 4'(SETUP_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state_reg, state_next;
    logic [3:0]              setup_cnt_reg;
    logic [7:0]              wait_cnt_reg;
    logic                    is_read_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    timeout_err_reg;

    // State register; Reset aborts any access at the next edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. MFC is checked before the timeout, so MFC wins when
    // both happen in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Req_Read || Req_Write) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_reg == SETUP_LAST) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (RAM1_MFC) begin
                    state_next = ST_COMPLETE;
                end else if (wait_cnt_reg == TIMEOUT_LAST) begin
                    state_next = ST_FAIL;
                end
            end
            ST_COMPLETE, ST_FAIL: begin
                // A lingering MFC has to drop before the next access may start.
                state_next = RAM1_MFC ? ST_RELEASE : ST_IDLE;
            end
            ST_RELEASE: begin
                if (!RAM1_MFC) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch, phase counters, read-data capture and sticky timeout flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            setup_cnt_reg   <= '0;
            wait_cnt_reg    <= '0;
            is_read_reg     <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            rdata_reg       <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && (Req_Read || Req_Write)) begin
                is_read_reg <= Req_Read;   // read wins when both are high
                addr_reg    <= Req_Address;
                wdata_reg   <= Req_Write_Data;
            end

            if (state_reg == ST_SETUP && state_next == ST_SETUP) begin
                setup_cnt_reg <= setup_cnt_reg + 4'd1;
            end else begin
                setup_cnt_reg <= '0;
            end

            if (state_reg == ST_ACCESS) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end else begin
                wait_cnt_reg <= '0;
            end

            if (state_reg == ST_ACCESS && RAM1_MFC && is_read_reg) begin
                rdata_reg <= RAM1_Data_Out;
            end

            // A new timeout takes priority over a clear in the same cycle.
            if (state_reg == ST_ACCESS && state_next == ST_FAIL) begin
                timeout_err_reg <= 1'b1;
            end else if (Error_Clear) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

    // Outputs are decoded from the registered state and held registers.
    always_comb begin
        Busy                = (state_reg != ST_IDLE);
        Done                = (state_reg == ST_COMPLETE) || (state_reg == ST_FAIL);
        RAM1_Out_Enable     = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
        RAM1_Read_H_Write_L = !((state_reg == ST_ACCESS) && !is_read_reg);
        RAM1_Address        = addr_reg;
        RAM1_Data_In        = wdata_reg;
        Read_Data           = rdata_reg;
        Timeout_Error       = timeout_err_reg;
    end

endmodule
